// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// access-size masks and the misalignment rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        REQ2,
        WAIT2
    } lsu_state_e;

    localparam logic [3:0] SIZE_BYTE_MASK = 4'b0001;
    localparam logic [3:0] SIZE_HALF_MASK = 4'b0011;
    localparam logic [3:0] SIZE_WORD_MASK = 4'b1111;

    function automatic logic size_is_legal(input logic [3:0] size);
        return (size == SIZE_BYTE_MASK) || (size == SIZE_HALF_MASK) ||
               (size == SIZE_WORD_MASK);
    endfunction

    // An access is misaligned when its bytes cross into the next bus word.
    function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF_MASK) && (off == 2'd3)) ||
               ((size == SIZE_WORD_MASK) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store shift and byte enables
// (low or high word of the 8-lane window), load shift and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic            unsigned_i,
    input  logic            hi_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_lo_i,
    input  logic [XLEN-1:0] rdata_hi_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [7:0]        be8;
    logic [2*XLEN-1:0] wdata64;
    logic [XLEN-1:0]   rshift;

    assign be8     = {4'b0000, size_i} << off_i;
    assign wdata64 = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    assign be_o    = hi_i ? be8[7:4] : be8[3:0];
    assign wdata_o = hi_i ? wdata64[2*XLEN-1:XLEN] : wdata64[XLEN-1:0];
    assign rshift  = XLEN'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

    always_comb begin
        case (size_i)
            SIZE_BYTE_MASK: rdata_o = unsigned_i ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                                 : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            SIZE_HALF_MASK: rdata_o = unsigned_i ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                                 : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            default:        rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding word-aligned DMEM transaction, pipeline stall
// until response. Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses in two.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [3:0]      d_size_i,
    input  logic            d_unsigned_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            rdata_valid_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      size_q;
    logic            uns_q, we_q;
    logic            req_any, legal, mis, accept, final_rvalid, sel_hi;
    logic [XLEN-3:0] word_addr;
    logic [3:0]      be;
    logic [XLEN-1:0] bus_wdata, ld_lo, ld_hi, ld_data;

    // Gated by reset so the accept-cycle outputs are also 0 while rst_i is high.
    assign req_any = !rst_i && (mem_read_i || mem_write_i);
    assign legal   = size_is_legal(d_size_i);
    assign mis     = is_misaligned(d_size_i, addr_i[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic            split_q;
    logic [XLEN-1:0] first_q;

    assign accept       = (state_q == IDLE) && req_any && legal;
    assign misalign_o   = 1'b0;
    assign final_rvalid = dmem_rvalid_i &&
                          (((state_q == WAIT) && !split_q) || (state_q == WAIT2));
    assign ld_lo        = split_q ? first_q : dmem_rdata_i;
    assign ld_hi        = split_q ? dmem_rdata_i : '0;
`else
    assign accept       = (state_q == IDLE) && req_any && legal && !mis;
    assign misalign_o   = (state_q == IDLE) && req_any && legal && mis;
    assign final_rvalid = dmem_rvalid_i && (state_q == WAIT);
    assign ld_lo        = dmem_rdata_i;
    assign ld_hi        = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = REQ;
            REQ:     if (dmem_gnt_i)    state_d = WAIT;
            WAIT:    if (dmem_rvalid_i) state_d = final_rvalid ? IDLE : REQ2;
            REQ2:    if (dmem_gnt_i)    state_d = WAIT2;
            WAIT2:   if (dmem_rvalid_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = 1'b0;
        sel_hi     = 1'b0;
        case (state_q)
            REQ:     dmem_req_o = 1'b1;
            REQ2:    begin dmem_req_o = 1'b1; sel_hi = 1'b1; end
            default: ;
        endcase
        stall_o       = accept || ((state_q != IDLE) && !final_rvalid);
        rdata_valid_o = final_rvalid && !we_q;
        dmem_we_o     = dmem_req_o && we_q;
        dmem_be_o     = dmem_req_o ? be : 4'b0000;
        dmem_addr_o   = dmem_req_o ? {word_addr, 2'b00} : '0;
        dmem_wdata_o  = dmem_req_o ? bus_wdata : '0;
        rdata_o       = rdata_valid_o ? ld_data : '0;
    end

    assign word_addr = addr_q[XLEN-1:2] + (XLEN-2)'(sel_hi);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
            first_q <= '0;
`endif
        end else begin
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                size_q  <= d_size_i;
                uns_q   <= d_unsigned_i;
                we_q    <= mem_write_i;
`ifdef LSU_MISALIGN_SPLIT_EN
                split_q <= mis;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((state_q == WAIT) && dmem_rvalid_i) first_q <= dmem_rdata_i;
`endif
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .unsigned_i (uns_q),
        .hi_i       (sel_hi),
        .wdata_i    (wdata_q),
        .rdata_lo_i (ld_lo),
        .rdata_hi_i (ld_hi),
        .be_o       (be),
        .wdata_o    (bus_wdata),
        .rdata_o    (ld_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change 1 ns after posedge,
// outputs are sampled 4 ns after posedge.
module tb_load_store_unit;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            mem_read_i, mem_write_i, d_unsigned_i;
    logic [3:0]      d_size_i;
    logic [XLEN-1:0] addr_i, wdata_i;
    logic            stall_o, rdata_valid_o, misalign_o;
    logic [XLEN-1:0] rdata_o;
    logic            dmem_req_o, dmem_we_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
    logic            dmem_gnt_i, dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .d_size_i      (d_size_i),
        .d_unsigned_i  (d_unsigned_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misalign_o    (misalign_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_req();
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        d_size_i     = 4'b0000;
        d_unsigned_i = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        mem_read_i   = rd;
        mem_write_i  = wr;
        d_size_i     = size;
        d_unsigned_i = uns;
        addr_i       = addr;
        wdata_i      = wd;
    endtask

    task automatic test_reset();
        logic [104:0] outs;
        rst_i = 1'b1;
        clear_req();
        mem_read_i    = 1'b1;
        d_size_i      = 4'b1111;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        #2;
        outs = {stall_o, rdata_valid_o, misalign_o, dmem_req_o, dmem_we_o, dmem_be_o,
                dmem_addr_o, dmem_wdata_o, rdata_o};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        cyc();
        clear_req();
        dmem_rdata_i = '0;
        rst_i = 1'b0;
        settle();
        total++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            bad++; $display("FAIL reset_release got=%b exp=00", {stall_o, dmem_req_o});
        end
    endtask

    task automatic test_store_word();
        cyc();
        issue(1'b0, 1'b1, 4'b1111, 1'b0, 32'h100, 32'hDEAD_BEEF);
        settle();
        total++;
        if ({stall_o, dmem_req_o} !== 2'b10) begin
            bad++; $display("FAIL sw_t0 stall/req got=%b exp=10", {stall_o, dmem_req_o});
        end
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if ({stall_o, dmem_req_o, dmem_we_o, dmem_be_o} !== 7'b111_1111) begin
            bad++; $display("FAIL sw_t1 ctl got=%b exp=1111111", {stall_o, dmem_req_o, dmem_we_o, dmem_be_o});
        end
        total++;
        if ({dmem_addr_o, dmem_wdata_o} !== {32'h100, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL sw_t1 addr/data got=%h/%h exp=100/deadbeef", dmem_addr_o, dmem_wdata_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        settle();
        total++;
        if ({stall_o, dmem_req_o, rdata_valid_o} !== 3'b000) begin
            bad++; $display("FAIL sw_t2 stall/req/rv got=%b exp=000", {stall_o, dmem_req_o, rdata_valid_o});
        end
        cyc();
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        cyc();
        issue(1'b1, 1'b0, 4'b0001, uns, 32'h103, 32'h0);
        settle();
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL lb_t0_stall uns=%b got=%b exp=1", uns, stall_o); end
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o} !== {1'b1, 1'b0, 4'b1000, 32'h100}) begin
            bad++; $display("FAIL lb_t1_bus uns=%b got=%b %b %b %h exp=1 0 1000 100", uns,
                            dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80AA_BBCC;
        settle();
        total++;
        if ({stall_o, rdata_valid_o, rdata_o} !== {1'b0, 1'b1, exp}) begin
            bad++; $display("FAIL lb_t2_data uns=%b got=%b %b %h exp=0 1 %h", uns,
                            stall_o, rdata_valid_o, rdata_o, exp);
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        settle();
        total++;
        if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL lb_t3_pulse got=%b exp=0", rdata_valid_o); end
    endtask

    task automatic test_store_half();
        cyc();
        issue(1'b0, 1'b1, 4'b0011, 1'b0, 32'h102, 32'h0000_1234);
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if ({dmem_be_o, dmem_addr_o, dmem_wdata_o} !== {4'b1100, 32'h100, 32'h1234_0000}) begin
            bad++; $display("FAIL sh_bus got=%b %h %h exp=1100 100 12340000", dmem_be_o, dmem_addr_o, dmem_wdata_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        cyc();
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_both_is_write();
        cyc();
        issue(1'b1, 1'b1, 4'b0001, 1'b0, 32'h001, 32'h0000_00A5);
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if ({dmem_we_o, dmem_be_o, dmem_wdata_o} !== {1'b1, 4'b0010, 32'h0000_A500}) begin
            bad++; $display("FAIL rw_bus got=%b %b %h exp=1 0010 0000a500", dmem_we_o, dmem_be_o, dmem_wdata_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_1111;
        settle();
        total++;
        if ({stall_o, rdata_valid_o} !== 2'b00) begin
            bad++; $display("FAIL rw_done got=%b exp=00", {stall_o, rdata_valid_o});
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
    endtask

    task automatic test_grant_wait();
        int stall_cnt = 0;
        cyc();
        issue(1'b0, 1'b1, 4'b1111, 1'b0, 32'h200, 32'hCAFE_F00D);
        settle();
        if (stall_o === 1'b1) stall_cnt++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            clear_req();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = (i == 1);
            settle();
            if (stall_o === 1'b1) stall_cnt++;
            total++;
            if ({dmem_req_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !==
                {1'b1, 4'b1111, 32'h200, 32'hCAFE_F00D}) begin
                bad++; $display("FAIL gw_hold cyc=%0d got=%b %b %h %h exp=1 1111 200 cafef00d", i,
                                dmem_req_o, dmem_be_o, dmem_addr_o, dmem_wdata_o);
            end
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b1;
        settle();
        if (stall_o === 1'b1) stall_cnt++;
        total++;
        if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL gw_grant_req got=%b exp=1", dmem_req_o); end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        settle();
        if (stall_o === 1'b1) stall_cnt++;
        total++;
        if (stall_cnt !== 5) begin bad++; $display("FAIL gw_stall_cycles got=%0d exp=5", stall_cnt); end
        cyc();
        dmem_rvalid_i = 1'b0;
        settle();
        total++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            bad++; $display("FAIL gw_idle got=%b exp=00", {stall_o, dmem_req_o});
        end
    endtask

    task automatic test_illegal_size();
        cyc();
        issue(1'b1, 1'b0, 4'b0111, 1'b0, 32'h010, 32'h0);
        settle();
        total++;
        if ({stall_o, misalign_o} !== 2'b00) begin
            bad++; $display("FAIL ill_t0 got=%b exp=00", {stall_o, misalign_o});
        end
        cyc();
        clear_req();
        settle();
        total++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            bad++; $display("FAIL ill_t1 got=%b exp=00", {stall_o, dmem_req_o});
        end
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_misalign();
        cyc();
        issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h101, 32'h0);
        settle();
        total++;
        if ({stall_o, misalign_o} !== 2'b10) begin
            bad++; $display("FAIL mis_t0 got=%b exp=10", {stall_o, misalign_o});
        end
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if ({dmem_req_o, dmem_be_o, dmem_addr_o} !== {1'b1, 4'b1110, 32'h100}) begin
            bad++; $display("FAIL mis_first got=%b %b %h exp=1 1110 100", dmem_req_o, dmem_be_o, dmem_addr_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h4433_2211;
        settle();
        total++;
        if ({stall_o, rdata_valid_o} !== 2'b10) begin
            bad++; $display("FAIL mis_mid got=%b exp=10", {stall_o, rdata_valid_o});
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        dmem_gnt_i    = 1'b1;
        settle();
        total++;
        if ({dmem_req_o, dmem_be_o, dmem_addr_o} !== {1'b1, 4'b0001, 32'h104}) begin
            bad++; $display("FAIL mis_second got=%b %b %h exp=1 0001 104", dmem_req_o, dmem_be_o, dmem_addr_o);
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h8877_6655;
        settle();
        total++;
        if ({stall_o, rdata_valid_o, rdata_o} !== {1'b0, 1'b1, 32'h5544_3322}) begin
            bad++; $display("FAIL mis_data got=%b %b %h exp=0 1 55443322", stall_o, rdata_valid_o, rdata_o);
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
    endtask
`else
    task automatic test_misalign();
        cyc();
        issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h101, 32'h0);
        settle();
        total++;
        if ({misalign_o, stall_o} !== 2'b10) begin
            bad++; $display("FAIL mis_t0 got=%b exp=10", {misalign_o, stall_o});
        end
        cyc();
        clear_req();
        settle();
        total++;
        if ({misalign_o, stall_o, dmem_req_o} !== 3'b000) begin
            bad++; $display("FAIL mis_t1 got=%b exp=000", {misalign_o, stall_o, dmem_req_o});
        end
        cyc();
        settle();
        total++;
        if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL mis_t2_req got=%b exp=0", dmem_req_o); end
    endtask
`endif

    task automatic test_reset_mid();
        cyc();
        issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h300, 32'h0);
        cyc();
        clear_req();
        dmem_gnt_i = 1'b1;
        settle();
        total++;
        if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", dmem_req_o); end
        cyc();
        dmem_gnt_i = 1'b0;
        settle();
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL rm_wait_stall got=%b exp=1", stall_o); end
        #1;
        rst_i = 1'b1;
        #1;
        total++;
        if ({stall_o, dmem_req_o, rdata_valid_o} !== 3'b000) begin
            bad++; $display("FAIL rm_async got=%b exp=000", {stall_o, dmem_req_o, rdata_valid_o});
        end
        cyc();
        rst_i = 1'b0;
        cyc();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        settle();
        total++;
        if ({stall_o, rdata_valid_o, rdata_o} !== {2'b00, 32'h0}) begin
            bad++; $display("FAIL rm_late_rvalid got=%b %b %h exp=0 0 0", stall_o, rdata_valid_o, rdata_o);
        end
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_both_is_write();
        test_grant_wait();
        test_illegal_size();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
